// File: rtl/packet_ram_read_arbiter.sv
// packet_ram_read_arbiter
//   Shares the single read port of the packet buffer RAM driver between two
//   stream readers. Requester 0 is the UART TX stream reader and requester 1
//   is the Ethernet frame generator.
//   Each requester owns a one-entry pending slot. At most one read is issued
//   per cycle, and contests are granted round-robin. A tag shift register,
//   matched to the RAM read latency, routes each returned byte to the
//   requester that asked for it.
//
// Build option:
//   PKT_ARB_FIXED_PRIORITY_EN  When defined, requester 0 always wins a contest.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   reqN_readclk, reqN_raddr  read strobe and address from requester N
//   reqN_busy                 slot of requester N is occupied; a strobe is refused
//   reqN_outclk, reqN_out     returned data valid and data for requester N
//   ram_readclk, ram_raddr    read strobe and address to the RAM driver
//   ram_outclk, ram_out       data valid and data from the RAM driver
//   err                       sticky protocol error flag
module packet_ram_read_arbiter #(
  parameter int ADDR_WIDTH       = 11,
  parameter int DATA_WIDTH       = 8,
  parameter int RAM_READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_readclk,
  input  logic [ADDR_WIDTH-1:0] req0_raddr,
  output logic                  req0_busy,
  output logic                  req0_outclk,
  output logic [DATA_WIDTH-1:0] req0_out,
  input  logic                  req1_readclk,
  input  logic [ADDR_WIDTH-1:0] req1_raddr,
  output logic                  req1_busy,
  output logic                  req1_outclk,
  output logic [DATA_WIDTH-1:0] req1_out,
  output logic                  ram_readclk,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic                  ram_outclk,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  err
);

  localparam int L = RAM_READ_LATENCY;

  logic                  pend0_q, pend0_d, pend1_q, pend1_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic                  last_grant_q, last_grant_d;
  // Bit k of each tag vector is tag stage k. Stage L-1 describes the byte
  // the RAM should be returning in the current cycle.
  logic [L-1:0]          tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic                  err_q, err_d;
  logic [3:0]            holdoff_q, holdoff_d;
  logic                  grant0, grant1, hold_active, ret_ok;

  // Grant decision, made from registered state only
  always_comb begin
`ifdef PKT_ARB_FIXED_PRIORITY_EN
    grant0 = pend0_q;
    grant1 = pend1_q && !pend0_q;
`else
    grant0 = pend0_q && (!pend1_q || last_grant_q);
    grant1 = pend1_q && (!pend0_q || !last_grant_q);
`endif
  end

  // A slot that is being issued this cycle can accept a new strobe at the same time
  assign req0_busy   = pend0_q && !grant0;
  assign req1_busy   = pend1_q && !grant1;
  assign ram_readclk = grant0 || grant1;
  assign ram_raddr   = grant0 ? addr0_q : (grant1 ? addr1_q : '0);

  // Return routing. While holdoff is running, the RAM may still return reads
  // that were launched before reset. Those bytes are dropped here.
  assign hold_active = (holdoff_q != 4'd0);
  assign ret_ok      = !hold_active && ram_outclk && tag_vld_q[L-1];
  assign req0_outclk = ret_ok && !tag_id_q[L-1];
  assign req1_outclk = ret_ok && tag_id_q[L-1];
  assign req0_out    = req0_outclk ? ram_out : '0;
  assign req1_out    = req1_outclk ? ram_out : '0;
  assign err         = err_q;

  always_comb begin
    pend0_d      = pend0_q;
    pend1_d      = pend1_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    holdoff_d    = hold_active ? holdoff_q - 4'd1 : 4'd0;

    if (grant0) begin
      pend0_d      = 1'b0;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      pend1_d      = 1'b0;
      last_grant_d = 1'b1;
    end
    if (grant1) pend1_d = 1'b0;

    if (req0_readclk && !req0_busy) begin
      pend0_d = 1'b1;
      addr0_d = req0_raddr;
    end
    if (req1_readclk && !req1_busy) begin
      pend1_d = 1'b1;
      addr1_d = req1_raddr;
    end

    if ((req0_readclk && req0_busy) || (req1_readclk && req1_busy)) err_d = 1'b1;
    if (!hold_active && (ram_outclk != tag_vld_q[L-1]))             err_d = 1'b1;

    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = grant0 || grant1;
    tag_id_d[0]  = grant1;
    for (int k = 1; k < L; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      err_q        <= 1'b0;
      holdoff_q    <= 4'(RAM_READ_LATENCY);
    end else begin
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      err_q        <= err_d;
      holdoff_q    <= holdoff_d;
    end
  end

  // Captured addresses. These are only meaningful while their pend bit is set.
  always_ff @(posedge clk) begin
    addr0_q <= addr0_d;
    addr1_q <= addr1_d;
  end

endmodule

// File: tb/tb_packet_ram_read_arbiter.sv
module tb_packet_ram_read_arbiter;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_readclk = 1'b0, req1_readclk = 1'b0;
  logic [10:0] req0_raddr = '0, req1_raddr = '0;
  logic        req0_busy, req1_busy, req0_outclk, req1_outclk;
  logic [7:0]  req0_out, req1_out;
  logic        ram_readclk, ram_outclk, err;
  logic [10:0] ram_raddr;
  logic [7:0]  ram_out;
  logic        inject = 1'b0;

  int checks = 0, failures = 0, cyc = 0;
  int last_out0 = -1, last_out1 = -1, n_out0 = 0, n_out1 = 0;
  logic [7:0] mem [2048];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  packet_ram_read_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .RAM_READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_readclk(req0_readclk), .req0_raddr(req0_raddr), .req0_busy(req0_busy),
    .req0_outclk(req0_outclk), .req0_out(req0_out),
    .req1_readclk(req1_readclk), .req1_raddr(req1_raddr), .req1_busy(req1_busy),
    .req1_outclk(req1_outclk), .req1_out(req1_out),
    .ram_readclk(ram_readclk), .ram_raddr(ram_raddr),
    .ram_outclk(ram_outclk), .ram_out(ram_out), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: the read data appears exactly L cycles after the strobe.
  // It is never reset, so reads in flight at reset come back as stale data.
  bit [L-1:0] rv;
  bit [7:0]   rd [L];
  always @(posedge clk) begin
    rv[0] <= ram_readclk;
    rd[0] <= mem[ram_raddr];
    for (int k = 1; k < L; k++) begin
      rv[k] <= rv[k-1];
      rd[k] <= rd[k-1];
    end
  end
  assign ram_outclk = rv[L-1] | inject;
  assign ram_out    = inject ? 8'h5A : rd[L-1];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops the expected byte whenever a requester sees data
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_outclk) begin
        if (exp0.size() == 0) check("req0_unexpected_outclk", 1, 0);
        else check("req0_data", req0_out, exp0.pop_front());
        last_out0 = cyc;
        n_out0++;
      end else check("req0_out_idle_zero", req0_out, 0);
      if (req1_outclk) begin
        if (exp1.size() == 0) check("req1_unexpected_outclk", 1, 0);
        else check("req1_data", req1_out, exp1.pop_front());
        last_out1 = cyc;
        n_out1++;
      end else check("req1_out_idle_zero", req1_out, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of requester activity. A strobe with push set is expected to be accepted.
  task automatic drive(input bit s0, input logic [10:0] a0, input bit p0,
                       input bit s1, input logic [10:0] a1, input bit p1);
    req0_readclk = s0; req0_raddr = a0;
    req1_readclk = s1; req1_raddr = a1;
    if (s0 && p0) exp0.push_back(mem[a0]);
    if (s1 && p1) exp1.push_back(mem[a1]);
    step();
    req0_readclk = 1'b0;
    req1_readclk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inject = 1'b0;
    exp0.delete();
    exp1.delete();
    step();
    check("rst_ram_readclk", ram_readclk, 0);
    check("rst_ram_raddr", ram_raddr, 0);
    check("rst_busy", {req1_busy, req0_busy}, 0);
    check("rst_outclk", {req1_outclk, req0_outclk}, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    idle(L + 2);
  endtask

  initial begin
    int t0, cnt, bad, own0, busy_seen, n0, n1, n_before;
    logic [10:0] a0, a1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[11'h123] = 8'hA5;
    step();
    do_reset();

    // Single uncontested read
    t0 = cyc;
    drive(1, 11'h123, 1, 0, '0, 0);
    check("t1_ram_readclk", ram_readclk, 1);
    check("t1_ram_raddr", ram_raddr, 11'h123);
    idle(L + 2);
    check("t1_latency", last_out0, t0 + 1 + L);
    check("t1_req1_count", n_out1, 0);
    check("t1_err", err, 0);

    // Simultaneous first requests after reset
    do_reset();
    t0 = cyc;
    drive(1, 11'h010, 1, 1, 11'h020, 1);
    check("t2_first_raddr", ram_readclk ? int'(ram_raddr) : -1, 11'h010);
    idle(1);
    check("t2_second_raddr", ram_readclk ? int'(ram_raddr) : -1, 11'h020);
    idle(L + 2);
    check("t2_req0_time", last_out0, t0 + 1 + L);
    check("t2_req1_time", last_out1, t0 + 2 + L);

    // Sustained contention for 20 grant cycles
    do_reset();
    a0 = 11'h100; a1 = 11'h400; cnt = 0; bad = 0; own0 = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k >= 1) begin
        if (ram_readclk) cnt++;
        if (!ram_raddr[10]) own0++;
`ifdef PKT_ARB_FIXED_PRIORITY_EN
        if (ram_raddr[10] != 1'b0) bad++;
`else
        if (ram_raddr[10] != ((k - 1) % 2 == 1)) bad++;
`endif
      end
      drive(!req0_busy, a0, 1, !req1_busy, a1, 1);
      if (req0_readclk === 1'b0) ;
      a0 = a0 + 11'(1);
      a1 = a1 + 11'(1);
    end
    check("t3_readclk_every_cycle", cnt, 20);
    check("t3_grant_pattern_errors", bad, 0);
`ifdef PKT_ARB_FIXED_PRIORITY_EN
    check("t3_req0_grants", own0, 20);
`else
    check("t3_req0_grants", own0, 10);
`endif
    idle(L + 4);
    check("t3_queues_drained", exp0.size() + exp1.size(), 0);
    check("t3_err", err, 0);

    // Back-to-back reads from requester 1
    cnt = 0; busy_seen = 0; n_before = n_out1;
    for (int i = 0; i < 16; i++) begin
      if (i >= 1 && ram_readclk) cnt++;
      if (req1_busy) busy_seen++;
      drive(0, '0, 0, 1, 11'(i), 1);
    end
    if (ram_readclk) cnt++;
    idle(L + 2);
    check("t4_busy_seen", busy_seen, 0);
    check("t4_readclk_pulses", cnt, 16);
    check("t4_outclk_pulses", n_out1 - n_before, 16);

    // Refused strobe while req1 holds the grant
    do_reset();
    drive(1, 11'h200, 1, 1, 11'h600, 1);
    check("t5_grant0_raddr", ram_raddr, 11'h200);
    drive(1, 11'h201, 1, 0, '0, 0);
`ifndef PKT_ARB_FIXED_PRIORITY_EN
    check("t5_req0_busy", req0_busy, 1);
    check("t5_err_before", err, 0);
    drive(1, 11'h202, 0, 0, '0, 0);
    check("t5_err_set", err, 1);
    idle(L + 4);
    check("t5_err_sticky", err, 1);
`else
    idle(L + 4);
`endif
    check("t5_queues_drained", exp0.size() + exp1.size(), 0);

    // Stray RAM data with no tag in flight
    do_reset();
    check("t6_err_before", err, 0);
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("t6_err_set", err, 1);
    idle(3);
    check("t6_err_sticky", err, 1);

    // Reset one cycle after a read was launched
    do_reset();
    drive(1, 11'h300, 1, 0, '0, 0);
    check("t7_readclk", ram_readclk, 1);
    step();
    rst = 1'b1;
    exp0.delete();
    step();
    rst = 1'b0;
    n_before = n_out0 + n_out1;
    idle(L + 2);
    check("t7_no_stale_route", n_out0 + n_out1 - n_before, 0);
    check("t7_err_clear", err, 0);
    t0 = cyc;
    drive(1, 11'h301, 1, 0, '0, 0);
    idle(L + 2);
    check("t7_new_read_time", last_out0, t0 + 1 + L);
    check("t7_err_after", err, 0);

    // Randomized traffic from well-behaved requesters
    n0 = n_out0; n1 = n_out1; cnt = 0;
    for (int i = 0; i < 400; i++) begin
      bit s0, s1;
      s0 = ($urandom_range(3, 0) != 0) && !req0_busy;
      s1 = ($urandom_range(2, 0) != 0) && !req1_busy;
      if (s0) cnt++;
      if (s1) cnt++;
      drive(s0, 11'($urandom_range(2047, 0)), 1, s1, 11'($urandom_range(2047, 0)), 1);
    end
    idle(L + 4);
    check("rand_queues_drained", exp0.size() + exp1.size(), 0);
    check("rand_return_count", (n_out0 - n0) + (n_out1 - n1), cnt);
    check("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
